// File: rtl/spart_driver.sv
// Processor-replacement bus master for the SPART: programs the baud divisor, then echoes
// received bytes through a small FIFO. Define SPART_DRV_STATS_EN to add rx/tx byte counters.
module spart_driver #(
  parameter int CLK_HZ     = 100000000,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         br_cfg,
  output logic               iocs,
  output logic               iorw,
  output logic [1:0]         ioaddr,
  inout  wire  [7:0]         databus,
  input  logic               rda,
  input  logic               tbr,
  output logic               cfg_done,
`ifdef SPART_DRV_STATS_EN
  output logic [15:0]        rx_count,
  output logic [15:0]        tx_count,
`endif
  output logic [FIFO_AW:0]   fifo_cnt
);

  localparam logic [15:0] DIV_4800  = 16'((CLK_HZ + 8 * 4800)  / (16 * 4800)  - 1);
  localparam logic [15:0] DIV_9600  = 16'((CLK_HZ + 8 * 9600)  / (16 * 9600)  - 1);
  localparam logic [15:0] DIV_19200 = 16'((CLK_HZ + 8 * 19200) / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'((CLK_HZ + 8 * 38400) / (16 * 38400) - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = FIFO_DEPTH[FIFO_AW:0];

  typedef enum logic [2:0] {CFG_LO, GAP_LO, CFG_HI, GAP_HI, RUN, RD, WR, GAP_RUN} state_t;

  function automatic logic [15:0] div_sel(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_4800;
      2'b01:   return DIV_9600;
      2'b10:   return DIV_19200;
      default: return DIV_38400;
    endcase
  endfunction

  state_t state_q, state_d;
  logic [1:0] br_meta, br_sync, cfg_q;
  logic [15:0] div_lo_src, div_hi_src;
  logic bus_cs, bus_wr, push, pop, full, empty;
  logic [1:0] bus_addr;
  logic [7:0] bus_dout;
  logic [7:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] cnt;

  // Unreset synchronizer: it keeps tracking the switches while reset is held, so the
  // first divisor written after release already matches br_cfg.
  always_ff @(posedge clk) begin
    br_meta <= br_cfg;
    br_sync <= br_meta;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CFG_LO;
      cfg_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == CFG_LO) cfg_q <= br_sync;
    end
  end

  assign div_lo_src = div_sel(br_sync);
  assign div_hi_src = div_sel(cfg_q);
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  always_comb begin
    state_d  = state_q;
    bus_cs   = 1'b0;
    bus_wr   = 1'b0;
    bus_addr = 2'b00;
    bus_dout = 8'h00;
    push     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      CFG_LO: begin
        bus_cs   = 1'b1;
        bus_wr   = 1'b1;
        bus_addr = 2'b10;
        bus_dout = div_lo_src[7:0];
        state_d  = GAP_LO;
      end
      GAP_LO: state_d = CFG_HI;
      CFG_HI: begin
        bus_cs   = 1'b1;
        bus_wr   = 1'b1;
        bus_addr = 2'b11;
        bus_dout = div_hi_src[15:8];
        state_d  = GAP_HI;
      end
      GAP_HI: state_d = RUN;
      RUN: begin
        if (br_sync != cfg_q)     state_d = CFG_LO;
        else if (rda && !full)    state_d = RD;
        else if (tbr && !empty)   state_d = WR;
      end
      RD: begin
        bus_cs  = 1'b1;
        push    = 1'b1;
        state_d = GAP_RUN;
      end
      WR: begin
        bus_cs   = 1'b1;
        bus_wr   = 1'b1;
        bus_dout = mem[rd_ptr];
        pop      = 1'b1;
        state_d  = GAP_RUN;
      end
      GAP_RUN: state_d = RUN;
      default: state_d = CFG_LO;
    endcase
  end

  // Outputs are gated by reset so the bus is released the instant reset asserts.
  assign iocs     = rst & bus_cs;
  assign iorw     = ~(rst & bus_wr);
  assign ioaddr   = rst ? bus_addr : 2'b00;
  assign databus  = (iocs && !iorw) ? bus_dout : 8'hzz;
  assign cfg_done = (state_q == RUN) || (state_q == RD) || (state_q == WR) || (state_q == GAP_RUN);
  assign fifo_cnt = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= databus;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      cnt    <= cnt + 1'b1;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      cnt    <= cnt - 1'b1;
    end
  end

`ifdef SPART_DRV_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_count <= 16'h0000;
      tx_count <= 16'h0000;
    end else begin
      if (push) rx_count <= rx_count + 16'h0001;
      if (pop)  tx_count <= tx_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: a behavioural SPART on the bus, a byte-order echo
// model, table-driven divisor checks, directed corner sequences and a random echo run.
module tb_spart_driver;
  localparam int CLK_HZ = 100000000;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;

  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    logic [1:0] br;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  logic       iocs, iorw, cfg_done;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic [AW:0] fifo_cnt;
`ifdef SPART_DRV_STATS_EN
  logic [15:0] rx_count, tx_count;
`endif

  logic [7:0] rx_head = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] exp_echo[$];
  txn_t       txn_q[$];
  txn_t       cfg_log[$];
  bit         pop_req = 1'b0;
  bit         prev_cs = 1'b0;
  int         occ = 0;
  int         tests = 0;
  int         fails = 0;
  int         violations = 0;

  // The SPART drives the bus only during a read strobe; otherwise the pull-ups float it to FF.
  assign databus = (iocs && iorw) ? rx_head : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (databus[g]);
  end

  spart_driver #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .cfg_done (cfg_done),
`ifdef SPART_DRV_STATS_EN
    .rx_count (rx_count),
    .tx_count (tx_count),
`endif
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Bus observer: logs every strobe, tracks expected occupancy and echo order.
  always @(negedge clk) begin
    txn_t t;
    if (!rst) begin
      occ = 0;
      prev_cs = 1'b0;
    end else begin
      checkOutput("fifo_occupancy", 32'(fifo_cnt), 32'(occ));
      if (iocs && prev_cs) violations++;
      if (!iocs && databus !== 8'hFF) violations++;
      if (!iocs && !iorw) violations++;
      if (iocs) begin
        t.rw = iorw;
        t.addr = ioaddr;
        t.data = databus;
        txn_q.push_back(t);
        if (!iorw && ioaddr != 2'b00) cfg_log.push_back(t);
        if (iorw && ioaddr == 2'b00) begin
          occ++;
          pop_req = 1'b1;
        end
        if (!iorw && ioaddr == 2'b00) begin
          occ--;
          if (exp_echo.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL echo_unexpected: got write 0x%0h, required no write", databus);
          end else begin
            checkOutput("echo_data", 32'(databus), 32'(exp_echo.pop_front()));
          end
        end
      end
      prev_cs = iocs;
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_req && rx_q.size() > 0) void'(rx_q.pop_front());
    pop_req = 1'b0;
    rda = (rx_q.size() > 0);
    rx_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  task automatic applyStimulus(input logic [1:0] br);
    rst = 1'b0;
    br_cfg = br;
    tbr = 1'b0;
    rx_q.delete();
    exp_echo.delete();
    repeat (3) @(posedge clk);
    cfg_log.delete();
    txn_q.delete();
    #1 rst = 1'b1;
  endtask

  task automatic offerByte(input logic [7:0] b);
    rx_q.push_back(b);
    exp_echo.push_back(b);
  endtask

  task automatic waitCfg(input logic level, input string name, output int k);
    k = 0;
    @(negedge clk);
    while (cfg_done !== level && k < 60) begin
      k++;
      @(negedge clk);
    end
    if (k >= 60) checkOutput({name, "_timeout"}, 32'(cfg_done), 32'(level));
  endtask

  task automatic waitFifo(input int n, input string name);
    int k = 0;
    @(negedge clk);
    while (!(fifo_cnt == (AW+1)'(n) && rx_q.size() == 0 && !iocs) && k < 60) begin
      k++;
      @(negedge clk);
    end
    checkOutput(name, 32'(fifo_cnt), 32'(n));
  endtask

  task automatic waitWrite(input string name);
    int k = 0;
    @(negedge clk);
    while (!(iocs && !iorw && ioaddr == 2'b00) && k < 60) begin
      k++;
      @(negedge clk);
    end
    if (k >= 60) checkOutput({name, "_timeout"}, 32'(k), 32'd0);
  endtask

  task automatic drain(input string name);
    int k = 0;
    tbr = 1'b1;
    @(negedge clk);
    while (!(exp_echo.size() == 0 && rx_q.size() == 0 && fifo_cnt == '0 && !iocs) && k < 600) begin
      k++;
      @(negedge clk);
    end
    checkOutput({name, "_left"}, 32'(exp_echo.size()), 32'd0);
    checkOutput({name, "_cnt"}, 32'(fifo_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg_vec_t vec[4];
    int k, n;
    vec[0] = '{2'b00, 8'h15, 8'h05};
    vec[1] = '{2'b10, 8'h45, 8'h01};
    vec[2] = '{2'b11, 8'hA2, 8'h00};
    vec[3] = '{2'b01, 8'h8A, 8'h02};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_iocs", 32'(iocs), 32'd0);
    checkOutput("reset_iorw", 32'(iorw), 32'd1);
    checkOutput("reset_ioaddr", 32'(ioaddr), 32'd0);
    checkOutput("reset_databus", 32'(databus), 32'hFF);
    checkOutput("reset_cfg_done", 32'(cfg_done), 32'd0);
    checkOutput("reset_fifo_cnt", 32'(fifo_cnt), 32'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vec[i].br);
      waitCfg(1'b1, "cfg_done", k);
      checkOutput("cfg_latency", 32'(k), 32'd4);
      checkOutput("cfg_writes", 32'(cfg_log.size()), 32'd2);
      if (cfg_log.size() >= 2) begin
        checkOutput("cfg_lo", {22'd0, cfg_log[0].addr, cfg_log[0].data}, {22'd0, 2'b10, vec[i].lo});
        checkOutput("cfg_hi", {22'd0, cfg_log[1].addr, cfg_log[1].data}, {22'd0, 2'b11, vec[i].hi});
      end
    end

    // Single byte echo: read then write of the same byte.
    @(negedge clk);
    txn_q.delete();
    tbr = 1'b1;
    offerByte(8'h41);
    drain("single_echo");
    checkOutput("single_txns", 32'(txn_q.size()), 32'd2);
    if (txn_q.size() >= 2) begin
      checkOutput("single_rd", {23'd0, txn_q[0].rw, txn_q[0].addr, txn_q[0].data}, {23'd0, 1'b1, 2'b00, 8'h41});
      checkOutput("single_wr", {23'd0, txn_q[1].rw, txn_q[1].addr, txn_q[1].data}, {23'd0, 1'b0, 2'b00, 8'h41});
    end

    // Backpressure: five bytes offered with tbr low, only four fit.
    tbr = 1'b0;
    txn_q.delete();
    for (int b = 8'h10; b <= 8'h14; b++) offerByte(8'(b));
    repeat (40) @(negedge clk);
    checkOutput("full_fifo_cnt", 32'(fifo_cnt), 32'd4);
    checkOutput("full_pending", 32'(rx_q.size()), 32'd1);
    checkOutput("full_reads", 32'(txn_q.size()), 32'd4);
    drain("full_drain");

    // Read has priority when rda and tbr rise together.
    tbr = 1'b0;
    offerByte(8'h55);
    waitFifo(1, "prio_setup");
    offerByte(8'h66);
    k = 0;
    @(negedge clk);
    while (rda !== 1'b1 && k < 10) begin
      k++;
      @(negedge clk);
    end
    tbr = 1'b1;
    n = txn_q.size();
    drain("prio_drain");
    if (txn_q.size() >= n + 2) begin
      checkOutput("prio_first_rd", {23'd0, txn_q[n].rw, txn_q[n].addr, txn_q[n].data}, {23'd0, 1'b1, 2'b00, 8'h66});
      checkOutput("prio_then_wr", {23'd0, txn_q[n+1].rw, txn_q[n+1].addr, txn_q[n+1].data}, {23'd0, 1'b0, 2'b00, 8'h55});
    end else begin
      checkOutput("prio_txns", 32'(txn_q.size()), 32'(n + 2));
    end

    // Baud change during a write: finish the write, reprogram, keep the FIFO.
    tbr = 1'b0;
    offerByte(8'h21);
    offerByte(8'h22);
    waitFifo(2, "reconfig_setup");
    tbr = 1'b1;
    waitWrite("reconfig_wr");
    br_cfg = 2'b11;
    tbr = 1'b0;
    cfg_log.delete();
    waitCfg(1'b0, "reconfig_drop", k);
    waitCfg(1'b1, "reconfig_done", k);
    checkOutput("reconfig_writes", 32'(cfg_log.size()), 32'd2);
    if (cfg_log.size() >= 2) begin
      checkOutput("reconfig_lo", {22'd0, cfg_log[0].addr, cfg_log[0].data}, {22'd0, 2'b10, 8'hA2});
      checkOutput("reconfig_hi", {22'd0, cfg_log[1].addr, cfg_log[1].data}, {22'd0, 2'b11, 8'h00});
    end
    checkOutput("reconfig_fifo_kept", 32'(fifo_cnt), 32'd1);
    drain("reconfig_drain");

    // Reset in the middle of a write strobe.
    tbr = 1'b0;
    offerByte(8'h31);
    offerByte(8'h32);
    waitFifo(2, "rst_setup");
    tbr = 1'b1;
    waitWrite("rst_wr");
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_mid_iocs", 32'(iocs), 32'd0);
    checkOutput("rst_mid_iorw", 32'(iorw), 32'd1);
    checkOutput("rst_mid_databus", 32'(databus), 32'hFF);
    checkOutput("rst_mid_fifo_cnt", 32'(fifo_cnt), 32'd0);
`ifdef SPART_DRV_STATS_EN
    checkOutput("rst_mid_rx_count", 32'(rx_count), 32'd0);
    checkOutput("rst_mid_tx_count", 32'(tx_count), 32'd0);
`endif
    applyStimulus(2'b11);
    waitCfg(1'b1, "rst_reprog", k);
    checkOutput("rst_reprog_latency", 32'(k), 32'd4);
    if (cfg_log.size() >= 1)
      checkOutput("rst_reprog_lo", {22'd0, cfg_log[0].addr, cfg_log[0].data}, {22'd0, 2'b10, 8'hA2});
    else
      checkOutput("rst_reprog_writes", 32'(cfg_log.size()), 32'd2);

    // Random traffic: every offered byte must come back once, in order.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 2) == 0 && rx_q.size() < 6) offerByte(8'($urandom));
      tbr = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain("random_drain");

    checkOutput("bus_protocol", 32'(violations), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
